clock_cal_ctrl: RTL
===================

Name: clock_cal_ctrl

Overview:
- Central time/calendar sequencer for the digital clock.
- Holds BCD sec/min/hour/day/month/year registers and advances them on a 1 Hz tick.
- Resolves all joint rollover decisions: hour 23→00, month lengths 31/30/29/28, month 12→01, Gregorian leap year.
- Provides a key-driven set-mode FSM that selects one field at a time for adjustment; feeds the display mux.

Parameters:
- YEAR_RST, 16'h2024, BCD year loaded on clr.
- MON_RST, 8'h01, BCD month loaded on clr.
- DAY_RST, 8'h01, BCD day loaded on clr.

Ports:
- clk  in  1  system clock; all state on posedge.
- clr  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  one-clk-wide pulse, once per second.
- key_mode  in  1  debounced one-clk pulse; advance set-mode state.
- key_inc  in  1  debounced one-clk pulse; increment selected field.
- sec  out  8  BCD seconds, 00-59.
- min  out  8  BCD minutes, 00-59.
- hour  out  8  BCD hours, 00-23.
- day  out  8  BCD day, 01-maxday.
- month  out  8  BCD month, 01-12.
- year  out  16  BCD year, 0000-9999.
- mode  out  3  current FSM state encoding.
- sel  out  6  one-hot field under edit (bit5 year … bit0 sec); 0 in RUN.
- day_carry  out  1  one-clk pulse when the day advances in RUN.
- chime  out  1  hourly pulse (see Optional Feature).

Behaviour:
- Reset (clr=1, async): sec=min=hour=00, day=DAY_RST, month=MON_RST, year=YEAR_RST, mode=RUN, sel=0, day_carry=0, chime=0.
- FSM encoding: 0 RUN, 1 SET_YEAR, 2 SET_MON, 3 SET_DAY, 4 SET_HOUR, 5 SET_MIN, 6 SET_SEC.
  - State 7 is illegal and returns to RUN on the next clk.
- key_mode sequence: RUN→1→2→3→4→5→6→RUN; one step per pulse.
- RUN counting:
  - A tick is honoured iff the state is RUN at that edge, even if key_mode is also asserted.
  - Full carry chain resolves in one cycle; registers update on the same edge that samples the tick (outputs valid next cycle).
  - sec 59→00 carries to min; min 59→00 carries to hour; hour 23→00 carries to day.
  - day==maxday → 01 carries to month; month 12→01 carries to year; year 9999→0000.
- maxday:
  - 31 for months 01,03,05,07,08,10,12.
  - 30 for months 04,06,09,11.
  - February: 29 if leap, else 28.
- Leap rule, evaluated on BCD digits only (no binary conversion):
  - leap = (yy%4==0) and (yy!=00 or cc%4==0), where yy = low two digits and cc = high two digits.
  - Digit-pair mod 4: (tens odd ? units+2 : units) mod 4.
- day_carry: registered, high exactly one clk after a RUN tick that advances the day.
- SET states:
  - Time is frozen; ticks are ignored.
  - key_inc increments only the selected field, with wrap inside the field and no carry to neighbours.
  - Wrap points: year 9999→0000, month 12→01, day maxday→01, hour 23→00, min 59→00.
  - SET_SEC: key_inc clears sec to 00.
- Day clamp: if a month or year edit makes day > maxday, day is forced to maxday on the following clk (one-cycle registered clamp).
- Simultaneous key_mode and key_inc: key_mode wins; the inc is dropped.
- BCD increment: units 9→0 with a tens carry. Non-BCD register values never occur (reset and all updates are BCD-legal).
- clr mid-edit: immediate return to RUN with reset values.

Optional Feature:
- Macro: CLOCK_CAL_CHIME_EN.
- Defined: chime pulses high for one clk, registered, whenever a RUN tick produces min=00 and sec=00.
- Not defined: chime is tied to 0 and the compare logic is absent.

Test Plan:
- Reset: assert clr → 2024-01-01 00:00:00, mode=0, sel=0, day_carry=0.
- Year rollover: set 2023-12-31 23:59:59, pulse tick → 2024-01-01 00:00:00, day_carry one clk.
- Leap years:
  - 2024-02-28 23:59:59 + tick → 02-29.
  - 2100-02-28 23:59:59 + tick → 2100-03-01.
  - 2000-02-28 23:59:59 + tick → 2000-02-29.
- Set and clamp: on 2023-01-31, key_mode×2 (SET_MON), key_inc → month=02, day=28 one clk later; SET_DAY on day=28, key_inc → 01 with month unchanged.
- Priority and freeze:
  - key_mode+key_inc same clk in SET_HOUR → mode=5, hour unchanged.
  - tick in any SET state → no field change.
  - In RUN, tick+key_mode same clk → sec advances and mode=1.
- Mid-edit reset and chime: clr during SET_MIN → RUN with reset values. With CLOCK_CAL_CHIME_EN, 10:59:59 + tick → chime one clk; without the macro, chime stays 0.

Source files
------------

// File: rtl/clock_cal_ctrl_if.sv
// Port bundle for clock_cal_ctrl: key/tick inputs and BCD calendar outputs.
// The slave modport is the controller view; the master modport drives keys and reads time.
interface clock_cal_ctrl_if;
  logic        tick_1hz;
  logic        key_mode;
  logic        key_inc;
  logic [7:0]  sec;
  logic [7:0]  min;
  logic [7:0]  hour;
  logic [7:0]  day;
  logic [7:0]  month;
  logic [15:0] year;
  logic [2:0]  mode;
  logic [5:0]  sel;
  logic        day_carry;
  logic        chime;

  modport master (
    output tick_1hz, key_mode, key_inc,
    input  sec, min, hour, day, month, year, mode, sel, day_carry, chime
  );

  modport slave (
    input  tick_1hz, key_mode, key_inc,
    output sec, min, hour, day, month, year, mode, sel, day_carry, chime
  );
endinterface

// File: rtl/clock_cal_ctrl.sv
// BCD time/calendar sequencer with key-driven set-mode FSM.
// Optional hourly chime enabled by defining CLOCK_CAL_CHIME_EN.
module clock_cal_ctrl #(
  parameter logic [15:0] YEAR_RST = 16'h2024,
  parameter logic [7:0]  MON_RST  = 8'h01,
  parameter logic [7:0]  DAY_RST  = 8'h01
) (
  input  logic            clk,
  input  logic            clr,
  clock_cal_ctrl_if.slave bus
);

  // Inputs are single-cycle strobes sampled on posedge; there is no backpressure.
  // Outputs are registered and reflect the edge that consumed the strobe.
  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_SET_YEAR = 3'd1,
    S_SET_MON  = 3'd2,
    S_SET_DAY  = 3'd3,
    S_SET_HOUR = 3'd4,
    S_SET_MIN  = 3'd5,
    S_SET_SEC  = 3'd6,
    S_ILLEGAL  = 3'd7
  } state_t;

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A BCD pair mod 4: 10 is 2 mod 4, so an odd tens digit adds 2 to the units.
  function automatic logic [1:0] bcd_mod4(input logic [7:0] v);
    logic [3:0] t;
    t = v[3:0] + (v[4] ? 4'd2 : 4'd0);
    return t[1:0];
  endfunction

  state_t      r_state, w_state_nxt;
  logic [5:0]  w_sel;
  logic [7:0]  r_sec, r_min, r_hour, r_day, r_month;
  logic [15:0] r_year;
  logic [7:0]  w_sec_nxt, w_min_nxt, w_hour_nxt, w_day_nxt, w_month_nxt;
  logic [15:0] w_year_nxt;
  logic [7:0]  w_maxday;
  logic        r_day_carry;
  logic        w_leap, w_tick_run, w_inc;
  logic        w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_wrap, w_mon_wrap;
  logic        w_c_min, w_c_hour, w_c_day, w_c_mon, w_c_year;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:      if (bus.key_mode) w_state_nxt = S_SET_YEAR;
      S_SET_YEAR: if (bus.key_mode) w_state_nxt = S_SET_MON;
      S_SET_MON:  if (bus.key_mode) w_state_nxt = S_SET_DAY;
      S_SET_DAY:  if (bus.key_mode) w_state_nxt = S_SET_HOUR;
      S_SET_HOUR: if (bus.key_mode) w_state_nxt = S_SET_MIN;
      S_SET_MIN:  if (bus.key_mode) w_state_nxt = S_SET_SEC;
      S_SET_SEC:  if (bus.key_mode) w_state_nxt = S_RUN;
      default:    w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_sel = 6'b000000;
    case (r_state)
      S_SET_YEAR: w_sel = 6'b100000;
      S_SET_MON:  w_sel = 6'b010000;
      S_SET_DAY:  w_sel = 6'b001000;
      S_SET_HOUR: w_sel = 6'b000100;
      S_SET_MIN:  w_sel = 6'b000010;
      S_SET_SEC:  w_sel = 6'b000001;
      default:    w_sel = 6'b000000;
    endcase
  end

  assign w_leap = (bcd_mod4(r_year[7:0]) == 2'd0) &&
                  ((r_year[7:0] != 8'h00) || (bcd_mod4(r_year[15:8]) == 2'd0));

  always_comb begin
    w_maxday = 8'h31;
    case (r_month)
      8'h02:                      w_maxday = w_leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: w_maxday = 8'h30;
      default:                    w_maxday = 8'h31;
    endcase
  end

  assign w_tick_run  = bus.tick_1hz && (r_state == S_RUN);
  assign w_inc       = bus.key_inc && !bus.key_mode;
  assign w_sec_wrap  = (r_sec == 8'h59);
  assign w_min_wrap  = (r_min == 8'h59);
  assign w_hour_wrap = (r_hour == 8'h23);
  assign w_day_wrap  = (r_day >= w_maxday);
  assign w_mon_wrap  = (r_month == 8'h12);
  assign w_c_min     = w_tick_run && w_sec_wrap;
  assign w_c_hour    = w_c_min && w_min_wrap;
  assign w_c_day     = w_c_hour && w_hour_wrap;
  assign w_c_mon     = w_c_day && w_day_wrap;
  assign w_c_year    = w_c_mon && w_mon_wrap;

  always_comb begin
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hour_nxt  = r_hour;
    w_day_nxt   = r_day;
    w_month_nxt = r_month;
    w_year_nxt  = r_year;
    if (w_tick_run) begin
      w_sec_nxt = w_sec_wrap ? 8'h00 : bcd_inc8(r_sec);
      if (w_c_min)  w_min_nxt   = w_min_wrap  ? 8'h00 : bcd_inc8(r_min);
      if (w_c_hour) w_hour_nxt  = w_hour_wrap ? 8'h00 : bcd_inc8(r_hour);
      if (w_c_day)  w_day_nxt   = w_day_wrap  ? 8'h01 : bcd_inc8(r_day);
      if (w_c_mon)  w_month_nxt = w_mon_wrap  ? 8'h01 : bcd_inc8(r_month);
      if (w_c_year) w_year_nxt  = bcd_inc16(r_year);
    end else if (w_inc) begin
      case (r_state)
        S_SET_YEAR: w_year_nxt  = bcd_inc16(r_year);
        S_SET_MON:  w_month_nxt = w_mon_wrap  ? 8'h01 : bcd_inc8(r_month);
        S_SET_DAY:  w_day_nxt   = w_day_wrap  ? 8'h01 : bcd_inc8(r_day);
        S_SET_HOUR: w_hour_nxt  = w_hour_wrap ? 8'h00 : bcd_inc8(r_hour);
        S_SET_MIN:  w_min_nxt   = w_min_wrap  ? 8'h00 : bcd_inc8(r_min);
        S_SET_SEC:  w_sec_nxt   = 8'h00;
        default:    ;
      endcase
    end
    // Month/year edits can strand the day past month end; pull it back one cycle later.
    if (r_day > w_maxday) w_day_nxt = w_maxday;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sec       <= 8'h00;
      r_min       <= 8'h00;
      r_hour      <= 8'h00;
      r_day       <= DAY_RST;
      r_month     <= MON_RST;
      r_year      <= YEAR_RST;
      r_day_carry <= 1'b0;
    end else begin
      r_sec       <= w_sec_nxt;
      r_min       <= w_min_nxt;
      r_hour      <= w_hour_nxt;
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year      <= w_year_nxt;
      r_day_carry <= w_c_day;
    end
  end

`ifdef CLOCK_CAL_CHIME_EN
  logic r_chime;
  // A RUN tick that carries into the hour is exactly the one landing on mm:ss = 00:00.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_chime <= 1'b0;
    else     r_chime <= w_c_hour;
  end
  assign bus.chime = r_chime;
`else
  assign bus.chime = 1'b0;
`endif

  assign bus.sec       = r_sec;
  assign bus.min       = r_min;
  assign bus.hour      = r_hour;
  assign bus.day       = r_day;
  assign bus.month     = r_month;
  assign bus.year      = r_year;
  assign bus.mode      = r_state;
  assign bus.sel       = w_sel;
  assign bus.day_carry = r_day_carry;

endmodule
